// File: rtl/lc3_mem_bridge_if.sv
// lc3_mem_bridge_if -- bundle of controller-side and memory-side signals for
// the LC-3 memory bridge.
//   master : the bridge itself (takes controller strobes and memory
//            responses, drives read data, stall/error status and the memory
//            request).
//   slave  : the environment (controller + external memory).
// Controller side : mar, mdr_out, rd_req, wr_req -> rd_data, rd_valid, stall,
//                   bus_err
// Memory side     : mem_addr, mem_wdata, mem_req, mem_we -> mem_rdata, mem_ack
interface lc3_mem_bridge_if;
  logic [15:0] mar;
  logic [15:0] mdr_out;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        stall;
  logic        bus_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  mar, mdr_out, rd_req, wr_req, mem_rdata, mem_ack,
    output rd_data, rd_valid, stall, bus_err,
           mem_addr, mem_wdata, mem_req, mem_we
  );

  modport slave (
    output mar, mdr_out, rd_req, wr_req, mem_rdata, mem_ack,
    input  rd_data, rd_valid, stall, bus_err,
           mem_addr, mem_wdata, mem_req, mem_we
  );
endinterface

// File: rtl/lc3_mem_bridge.sv
// lc3_mem_bridge -- turns the LC-3 controller's single-cycle read/write
// strobes into a held req/ack transaction on an external memory, stalling the
// controller until the memory answers.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lc3_mem_bridge_if.master (controller strobes, read data/status,
//          memory request/response)
// Parameter TIMEOUT_CYCLES (1..255): wait cycles before an unanswered request
// is aborted.
// Optional macro LC3_MEM_BRIDGE_TIMEOUT_EN: enables the wait counter and the
// sticky bus_err flag. Without it the bridge waits forever and bus_err is 0.
module lc3_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clk,
  input  logic             rst,
  lc3_mem_bridge_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lc3_mem_bridge: TIMEOUT_CYCLES out of range 1..255");
  end

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   waiting;
  logic   tmo;

  assign waiting = (state == RD_WAIT) || (state == WR_WAIT);

  // Stall covers the request cycle itself so the controller holds until DONE.
  assign bus.stall = waiting || ((state == IDLE) && (bus.rd_req || bus.wr_req));

`ifdef LC3_MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wcnt;
  logic       err_q;

  // Fires on the wait cycle that would bring the count to TIMEOUT_CYCLES;
  // an ack in the same cycle takes precedence.
  assign tmo = waiting && !bus.mem_ack && (wcnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (!waiting)         wcnt <= '0;
      else if (!bus.mem_ack) wcnt <= wcnt + 8'd1;
      if (tmo) err_q <= 1'b1;
    end
  end

  assign bus.bus_err = err_q;
`else
  assign tmo         = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:             if (bus.rd_req)      state_nxt = RD_WAIT;
                        else if (bus.wr_req) state_nxt = WR_WAIT;
      RD_WAIT, WR_WAIT: if (bus.mem_ack || tmo) state_nxt = DONE;
      DONE:             state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
    end else begin
      state        <= state_nxt;
      bus.rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Read wins a collision; the write is simply dropped.
          if (bus.rd_req) begin
            bus.mem_addr <= bus.mar;
            bus.mem_we   <= 1'b0;
            bus.mem_req  <= 1'b1;
          end else if (bus.wr_req) begin
            bus.mem_addr  <= bus.mar;
            bus.mem_wdata <= bus.mdr_out;
            bus.mem_we    <= 1'b1;
            bus.mem_req   <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (bus.mem_ack || tmo) begin
            // Aborted reads return zero data but still pulse rd_valid so the
            // controller is released.
            bus.rd_data  <= bus.mem_ack ? bus.mem_rdata : 16'h0000;
            bus.rd_valid <= 1'b1;
            bus.mem_req  <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (bus.mem_ack || tmo) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_bridge.sv
// tb_lc3_mem_bridge -- directed self-checking bench for lc3_mem_bridge.
// Scenario tasks each drive the interface and compare outputs sampled 1ns
// after the rising edge against hand-computed values.
module tb_lc3_mem_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lc3_mem_bridge_if bus();

  lc3_mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mar = 16'h0; bus.mdr_out = 16'h0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    bus.mem_rdata = 16'h0; bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.rd_valid, bus.bus_err, bus.stall} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000",
        {bus.mem_req, bus.mem_we, bus.rd_valid, bus.bus_err, bus.stall});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rd_data} !== 48'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {bus.mem_addr, bus.mem_wdata, bus.rd_data});
    end
  endtask

  task automatic test_read();
    int n = 0;
    bus.mar = 16'h3000; bus.rd_req = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b1) begin bad++; $display("FAIL read_stall_idle got=%b exp=1", bus.stall); end
    tick();
    bus.rd_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n += int'(bus.mem_req);
      if (c == 0) begin
        total++;
        if ({bus.mem_addr, bus.mem_we, bus.stall} !== {16'h3000, 1'b0, 1'b1}) begin
          bad++; $display("FAIL read_req got=%h/%b/%b exp=3000/0/1", bus.mem_addr, bus.mem_we, bus.stall);
        end
      end
      if (c == 2) begin bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234; end
      tick();
    end
    bus.mem_ack = 1'b0;
    total++;
    if (n != 3) begin bad++; $display("FAIL read_req_cycles got=%0d exp=3", n); end
    total++;
    if ({bus.mem_req, bus.rd_valid, bus.stall, bus.rd_data} !== {1'b0, 1'b1, 1'b0, 16'h1234}) begin
      bad++; $display("FAIL read_done got=req%b vld%b stall%b data%h exp=req0 vld1 stall0 data1234",
        bus.mem_req, bus.rd_valid, bus.stall, bus.rd_data);
    end
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 16'h1234}) begin
      bad++; $display("FAIL read_after got=vld%b data%h exp=vld0 data1234", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_write();
    bus.mar = 16'h4001; bus.mdr_out = 16'hBEEF; bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 16'h4001, 16'hBEEF}) begin
      bad++; $display("FAIL write_req got=%b%b %h %h exp=11 4001 beef",
        bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    total++;
    if ({bus.mem_req, bus.mem_we, bus.rd_valid, bus.stall, bus.rd_data} !== {4'b0, 16'h1234}) begin
      bad++; $display("FAIL write_done got=req%b we%b vld%b stall%b data%h exp=0 0 0 0 1234",
        bus.mem_req, bus.mem_we, bus.rd_valid, bus.stall, bus.rd_data);
    end
    tick();
  endtask

  task automatic test_collision();
    logic we_seen = 1'b0;
    bus.mar = 16'h0010; bus.mdr_out = 16'h5555; bus.rd_req = 1'b1; bus.wr_req = 1'b1;
    tick();
    bus.wr_req = 1'b0; bus.mar = 16'h0020;   // rd_req stays high into RD_WAIT
    we_seen |= bus.mem_we;
    total++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'h0010}) begin
      bad++; $display("FAIL coll_req got=%b %h exp=1 0010", bus.mem_req, bus.mem_addr);
    end
    tick();
    we_seen |= bus.mem_we;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h00AA; bus.rd_req = 1'b0;
    tick();
    bus.mem_ack = 1'b0;
    we_seen |= bus.mem_we;
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_addr} !== {1'b1, 16'h00AA, 16'h0010}) begin
      bad++; $display("FAIL coll_done got=vld%b data%h addr%h exp=vld1 data00aa addr0010",
        bus.rd_valid, bus.rd_data, bus.mem_addr);
    end
    tick();
    we_seen |= bus.mem_we;
    total++;
    if ({bus.mem_req, we_seen} !== 2'b00) begin
      bad++; $display("FAIL coll_no_second got=req%b we_seen%b exp=0 0", bus.mem_req, we_seen);
    end
  endtask

  task automatic test_spurious_ack();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hFFFF;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    total++;
    if ({bus.rd_valid, bus.mem_req, bus.stall, bus.rd_data} !== {3'b0, 16'h00AA}) begin
      bad++; $display("FAIL spurious got=vld%b req%b stall%b data%h exp=0 0 0 00aa",
        bus.rd_valid, bus.mem_req, bus.stall, bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_read();
    bus.mar = 16'h1111; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    total++;
    if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b exp=1", bus.mem_req); end
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h9999;
    tick();
    rst = 1'b0; bus.mem_ack = 1'b0;
    total++;
    if ({bus.mem_req, bus.rd_valid, bus.stall, bus.mem_addr, bus.rd_data} !== 35'h0) begin
      bad++; $display("FAIL rstmid_state got=req%b vld%b stall%b addr%h data%h exp=0 0 0 0000 0000",
        bus.mem_req, bus.rd_valid, bus.stall, bus.mem_addr, bus.rd_data);
    end
    tick();
    total++;
    if ({bus.rd_valid, bus.rd_data} !== 17'h0) begin
      bad++; $display("FAIL rstmid_noack got=vld%b data%h exp=0 0000", bus.rd_valid, bus.rd_data);
    end
    bus.mar = 16'h2222; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h7777;
    tick();
    bus.mem_ack = 1'b0;
    total++;
    if ({bus.rd_valid, bus.rd_data, bus.mem_addr} !== {1'b1, 16'h7777, 16'h2222}) begin
      bad++; $display("FAIL rstmid_next got=vld%b data%h addr%h exp=1 7777 2222",
        bus.rd_valid, bus.rd_data, bus.mem_addr);
    end
    tick();
  endtask

`ifdef LC3_MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout_ack_race();
    bus.mar = 16'h0A00; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    tick(); tick(); tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;   // 4th wait cycle
    tick();
    bus.mem_ack = 1'b0;
    total++;
    if ({bus.rd_valid, bus.bus_err, bus.rd_data} !== {2'b10, 16'h5A5A}) begin
      bad++; $display("FAIL tmo_race got=vld%b err%b data%h exp=1 0 5a5a",
        bus.rd_valid, bus.bus_err, bus.rd_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n = 0;
    bus.mar = 16'h5000; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n += int'(bus.mem_req);
      tick();
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=4", n); end
    total++;
    if ({bus.mem_req, bus.bus_err, bus.rd_valid, bus.rd_data} !== {3'b011, 16'h0000}) begin
      bad++; $display("FAIL tmo_abort got=req%b err%b vld%b data%h exp=0 1 1 0000",
        bus.mem_req, bus.bus_err, bus.rd_valid, bus.rd_data);
    end
    tick();
    bus.mar = 16'h6000; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'hABCD;
    tick();
    bus.mem_ack = 1'b0;
    total++;
    if ({bus.rd_valid, bus.bus_err, bus.rd_data} !== {2'b11, 16'hABCD}) begin
      bad++; $display("FAIL tmo_sticky got=vld%b err%b data%h exp=1 1 abcd",
        bus.rd_valid, bus.bus_err, bus.rd_data);
    end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    bus.mar = 16'h5000; bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    total++;
    if ({bus.mem_req, bus.stall, bus.bus_err} !== 3'b110) begin
      bad++; $display("FAIL notmo_wait got=req%b stall%b err%b exp=1 1 0",
        bus.mem_req, bus.stall, bus.bus_err);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0BAD;
    tick();
    bus.mem_ack = 1'b0;
    total++;
    if ({bus.rd_valid, bus.bus_err, bus.rd_data} !== {2'b10, 16'h0BAD}) begin
      bad++; $display("FAIL notmo_done got=vld%b err%b data%h exp=1 0 0bad",
        bus.rd_valid, bus.bus_err, bus.rd_data);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
`ifdef LC3_MEM_BRIDGE_TIMEOUT_EN
    test_timeout_ack_race();
`endif
    test_read();
    test_write();
    test_collision();
    test_spurious_ack();
    test_reset_mid_read();
`ifdef LC3_MEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
